// File: rtl/proteus_unpacker.sv
// proteus_unpacker: unpacks P-bit values (P = 1..16) from a stream of packed WIDTH-bit words through an external rotating barrel shifter.
// Ports:
//    clk, rst                    clock, synchronous active-high reset
//    start, prec                 flush the buffer and latch the precision (0 or >OUT_W means OUT_W)
//    in_valid/in_ready/in_data   packed word input, LSB-first stream
//    rot_word/rot_shift/rot_in   to and from the shifter (rot_in is a combinational return)
//    out_valid/out_ready/out_data  one extracted value per handshake
//    busy                        buffer holds words or a value is pending
// Optional feature: with PROTEUS_UNPACK_SIGNED_EN defined, values are sign-extended from bit P-1;
// otherwise they are zero-extended.
module proteus_unpacker #(
   parameter int CTRL  = 5,
   parameter int WIDTH = 2**CTRL,
   parameter int OUT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [4:0]       prec,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] rot_word,
   output logic [CTRL-1:0]  rot_shift,
   input  logic [WIDTH-1:0] rot_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             busy
);
   logic [WIDTH-1:0] lo, hi, m;
   logic [1:0]       count;
   logic [CTRL-1:0]  ptr;
   logic [4:0]       p;
   logic [CTRL:0]    sum;
   logic             extract, fire, pop, push;
   logic [OUT_W-1:0] vmask, val;
   assign sum      = {1'b0, ptr} + (CTRL+1)'(p);
   assign extract  = count == 2'd2 || (count == 2'd1 && sum <= (CTRL+1)'(WIDTH));
   assign fire     = extract && (!out_valid || out_ready);
   assign pop      = fire && sum >= (CTRL+1)'(WIDTH);
   assign in_ready = !rst && !start && count != 2'd2;
   assign push     = in_valid && in_ready;
   assign busy     = count != 2'd0 || out_valid;
   // Bits below ptr come from hi so the value straddling lo/hi lands contiguously at bit 0 after rotation.
   assign m         = (WIDTH'(1) << ptr) - WIDTH'(1);
   assign rot_word  = (hi & m) | (lo & ~m);
   assign rot_shift = CTRL'(0) - ptr;
   // With P = OUT_W the shift wraps to zero, so the mask becomes all ones.
   assign vmask = (OUT_W'(1) << p) - OUT_W'(1);
`ifdef PROTEUS_UNPACK_SIGNED_EN
   assign val = (rot_in[OUT_W-1:0] & vmask) | (rot_in[p - 5'd1] ? ~vmask : '0);
`else
   assign val = rot_in[OUT_W-1:0] & vmask;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         count     <= 2'd0;
         ptr       <= '0;
         p         <= 5'(OUT_W);
         lo        <= '0;
         hi        <= '0;
      end else if (start) begin
         out_valid <= 1'b0;
         count     <= 2'd0;
         ptr       <= '0;
         p         <= (prec == 5'd0 || prec > 5'(OUT_W)) ? 5'(OUT_W) : prec;
      end else begin
         if (fire) begin
            out_data  <= val;
            out_valid <= 1'b1;
            ptr       <= sum[CTRL-1:0];
         end else if (out_ready)
            out_valid <= 1'b0;
         if (pop)
            lo <= hi;
         // Target slot is count, or count-1 when a pop shifts the buffer in the same cycle.
         if (push && count == {1'b0, pop})
            lo <= in_data;
         else if (push)
            hi <= in_data;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end
endmodule

// File: tb/tb_proteus_unpacker.sv
// tb_proteus_unpacker: scoreboard bench for proteus_unpacker with a behavioural rotate-left shifter.
module tb_proteus_unpacker;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [4:0]  prec = 5'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic [31:0] rot_word;
   logic [4:0]  rot_shift;
   logic [31:0] rot_in;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic        busy;
   logic [63:0] dd;
   logic [15:0] exp_q[$];
   logic        seen8 = 1'b0;
   int          checks = 0;
   int          errors = 0;

   proteus_unpacker dut (
      .clk(clk), .rst(rst), .start(start), .prec(prec),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .rot_word(rot_word), .rot_shift(rot_shift), .rot_in(rot_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      dd     = {rot_word, rot_word} << rot_shift;
      rot_in = dd[63:32];
   end

   always @(negedge clk) begin
      if (rot_shift == 5'd8)
         seen8 <= 1'b1;
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output got %h with empty scoreboard", out_data);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
               errors++;
               $display("FAIL out_data got %h exp %h", out_data, e);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h exp %h", name, got, want);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [4:0] pv);
      start = 1'b1;
      prec  = pv;
      cyc();
      start = 1'b0;
   endtask

   task automatic push(input logic [31:0] w);
      bit done = 0;
      in_valid = 1'b1;
      in_data  = w;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            cyc();
            done = 1;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL push_timeout got no in_ready exp in_ready=1");
      end
   endtask

   task automatic drain;
      bit done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0)
            done = 1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL drain_timeout got %0d pending exp 0", exp_q.size());
      end
      cyc();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("in_ready_in_rst", 32'(in_ready), 32'd0);
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      // P=8, single word, latency and idle afterwards
      cyc();
      do_start(5'd8);
      out_ready = 1'b1;
      exp_q.push_back(16'h0011); exp_q.push_back(16'h0022);
      exp_q.push_back(16'h0033); exp_q.push_back(16'h0044);
      push(32'h44332211);
      @(negedge clk);
      check("lat_not_yet", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("lat_valid", 32'(out_valid), 32'd1);
      drain();
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_in_ready", 32'(in_ready), 32'd1);

      // P=12 with a value straddling two words
      cyc();
      do_start(5'd12);
      seen8 = 1'b0;
      exp_q.push_back(16'h0321); exp_q.push_back(16'h0654); exp_q.push_back(16'h0987);
      exp_q.push_back(16'h0CBA); exp_q.push_back(16'h0FED);
      push(32'h87654321);
      push(32'h0FEDCBA9);
      drain();
      check("straddle_shift8", 32'(seen8), 32'd1);

      // P=4, extension of a value with its top bit set
      do_start(5'd4);
      exp_q.push_back(16'h0007);
`ifdef PROTEUS_UNPACK_SIGNED_EN
      exp_q.push_back(16'hFFFF);
`else
      exp_q.push_back(16'h000F);
`endif
      for (int i = 0; i < 6; i++) exp_q.push_back(16'h0000);
      push(32'h000000F7);
      drain();

      // P=8 with downstream stall
      do_start(5'd8);
      out_ready = 1'b0;
      for (int i = 0; i < 12; i++) exp_q.push_back(16'((i + 1) * 16'h11));
      push(32'h44332211);
      push(32'h88776655);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_data", 32'(out_data), 32'h0011);
         check("stall_in_ready", 32'(in_ready), 32'd0);
      end
      cyc();
      out_ready = 1'b1;
      push(32'hCCBBAA99);
      drain();

      // prec=0 clamps to 16
      do_start(5'd0);
      exp_q.push_back(16'hCAFE); exp_q.push_back(16'hBEEF);
      push(32'hBEEFCAFE);
      drain();

      // reset mid-stream
      do_start(5'd8);
      out_ready = 1'b0;
      push(32'h11111111);
      push(32'h22222222);
      @(negedge clk);
      check("pre_rst_full", 32'(in_ready), 32'd0);
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_valid", 32'(out_valid), 32'd0);
      check("post_rst_data", 32'(out_data), 32'd0);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      check("post_rst_busy", 32'(busy), 32'd0);
      cyc();
      out_ready = 1'b1;
      exp_q.push_back(16'h5678); exp_q.push_back(16'h1234);
      push(32'h12345678);
      drain();
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
